pico_cpu_param: RTL and testbench

- Parametrised successor of the 8-bit tiny RISC core: configurable data width and instruction-memory depth, 16-bit instructions, three-operand ALU, branches/jumps, and explicit start/halt run control.
- Program RAM is loaded over a dedicated write port while the core is idle or halted.
- Results leave through a valid/ready output port that stalls the core until accepted.
- Sits behind the TT top-level pin wrapper, which maps pins onto these ports.

---
 rtl/pico_cpu_pkg.sv | 36 +++
 rtl/pico_cpu_alu.sv | 34 +++
 rtl/pico_cpu_param.sv | 140 ++++++++++++++
 tb/tb_pico_cpu_param.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_cpu_pkg.sv
// Shared encodings for the parametrised pico CPU:
// opcodes, ALU functs, FSM states and instruction field positions.
package pico_cpu_pkg;

  localparam logic [2:0] OP_ALUR = 3'd0;
  localparam logic [2:0] OP_ALUI = 3'd1;
  localparam logic [2:0] OP_LDI  = 3'd2;
  localparam logic [2:0] OP_IN   = 3'd3;
  localparam logic [2:0] OP_OUT  = 3'd4;
  localparam logic [2:0] OP_BEQZ = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;
  localparam logic [2:0] FN_SLL = 3'd5;
  localparam logic [2:0] FN_SRL = 3'd6;
  localparam logic [2:0] FN_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int OP_LSB  = 13;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int FN_LSB  = 4;
  localparam int RS2_LSB = 0;

endpackage

// File: rtl/pico_cpu_alu.sv
// Combinational ALU; results wrap modulo 2**DATA_W.
module pico_cpu_alu
  import pico_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        funct,
  output logic [DATA_W-1:0] y
);

  localparam int SW = $clog2(DATA_W);

  logic [SW-1:0] sh;

  assign sh = b[SW-1:0];

  always_comb begin
    y = '0;
    unique case (funct)
      FN_ADD: y = a + b;
      FN_SUB: y = a - b;
      FN_AND: y = a & b;
      FN_OR:  y = a | b;
      FN_XOR: y = a ^ b;
      FN_SLL: y = a << sh;
      FN_SRL: y = a >> sh;
      FN_MUL: y = a * b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/pico_cpu_param.sv
// Two-cycle FETCH/EXEC core with loadable program RAM,
// eight registers and a valid/ready output port.
module pico_cpu_param
  import pico_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        state,
  output logic              halted
);

  state_t            st;
  logic [15:0]       imem [2**ADDR_W];
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];

  logic [2:0]        op, rd, rs1, fn, rs2;
  logic [DATA_W-1:0] ra, rb, alu_b, alu_y, wb;
  logic [DATA_W-1:0] imm4_x, imm8_x;
  logic [ADDR_W-1:0] tgt, pc_inc;
  logic              writes_rd, can_load, idle_like;

  assign op  = ir[OP_LSB +: 3];
  assign rd  = ir[RD_LSB +: 3];
  assign rs1 = ir[RS1_LSB +: 3];
  assign fn  = ir[FN_LSB +: 3];
  assign rs2 = ir[RS2_LSB +: 3];
  assign tgt = ir[ADDR_W-1:0];

  assign imm4_x = DATA_W'({12'b0, ir[3:0]});
  assign imm8_x = DATA_W'({8'b0, ir[7:0]});

  assign ra = (rs1 == 3'd0) ? '0 : regs[rs1];
  assign rb = (rs2 == 3'd0) ? '0 : regs[rs2];

  assign alu_b  = (op == OP_ALUI) ? imm4_x : rb;
  assign pc_inc = pc + ADDR_W'(1);

  assign writes_rd = (op == OP_ALUR) || (op == OP_ALUI) ||
                     (op == OP_LDI)  || (op == OP_IN);

  // A new OUT may load in the same cycle the old value is accepted.
  assign can_load  = !out_valid || out_ready;
  assign idle_like = (st == S_IDLE) || (st == S_HALT);

  pico_cpu_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a     (ra),
    .b     (alu_b),
    .funct (fn),
    .y     (alu_y)
  );

  always_comb begin
    wb = alu_y;
    if (op == OP_LDI)
      wb = imm8_x;
    else if (op == OP_IN)
      wb = in_data;
  end

  always_ff @(posedge clk) begin
    if (prog_we && idle_like)
      imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 8; i++)
        regs[i] <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (st)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc <= '0;
            st <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir <= imem[pc];
          st <= S_EXEC;
        end
        S_EXEC: begin
          unique case (op)
            OP_OUT: begin
              if (can_load) begin
                out_data  <= ra;
                out_valid <= 1'b1;
                pc        <= pc_inc;
                st        <= S_FETCH;
              end
            end
            OP_BEQZ: begin
              pc <= (ra == '0) ? tgt : pc_inc;
              st <= S_FETCH;
            end
            OP_JMP: begin
              pc <= tgt;
              st <= S_FETCH;
            end
            OP_HALT: begin
              st <= S_HALT;
            end
            default: begin
              if (writes_rd && rd != 3'd0)
                regs[rd] <= wb;
              pc <= pc_inc;
              st <= S_FETCH;
            end
          endcase
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign state  = st;
  assign halted = (st == S_HALT);

endmodule

// File: tb/tb_pico_cpu_param.sv
// Directed bench for pico_cpu_param (DATA_W=8, ADDR_W=4)
// with hand-computed outputs collected from the valid/ready port.
module tb_pico_cpu_param;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] pc;
  logic [1:0]    state;
  logic          halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] outq [$];
  logic          wrap_seen = 1'b0;
  logic [AW-1:0] pc_q = '0;
  logic [1:0]    st_q = '0;

  pico_cpu_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc        (pc),
    .state     (state),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && out_valid && out_ready)
      outq.push_back(out_data);

  always @(negedge clk) begin
    if (pc_q == 4'd15 && st_q == 2'd2 && pc == 4'd0 && state == 2'd1)
      wrap_seen = 1'b1;
    pc_q = pc;
    st_q = state;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alur(int rd, int a, int f, int b);
    return {3'd0, 3'(rd), 3'(a), 3'(f), 1'b0, 3'(b)};
  endfunction
  function automatic logic [15:0] alui(int rd, int a, int f, int imm);
    return {3'd1, 3'(rd), 3'(a), 3'(f), 4'(imm)};
  endfunction
  function automatic logic [15:0] ldi(int rd, int imm);
    return {3'd2, 3'(rd), 2'b0, 8'(imm)};
  endfunction
  function automatic logic [15:0] inp(int rd);
    return {3'd3, 3'(rd), 10'd0};
  endfunction
  function automatic logic [15:0] outr(int a);
    return {3'd4, 3'd0, 3'(a), 7'd0};
  endfunction
  function automatic logic [15:0] beqz(int a, int t);
    return {3'd5, 3'd0, 3'(a), 3'd0, 4'(t)};
  endfunction
  function automatic logic [15:0] jmp(int t);
    return {3'd6, 9'd0, 4'(t)};
  endfunction
  localparam logic [15:0] HALT_W = 16'hE000;

  function automatic logic [31:0] got_out(int i);
    return (i < outq.size()) ? 32'(outq[i]) : 32'hDEAD;
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int max);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!halted)
      chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_halted", 32'(halted), 0);

    // 1: basic ADD and OUT
    wr(0, ldi(1, 5));
    wr(1, ldi(2, 3));
    wr(2, alur(3, 1, 0, 2));
    wr(3, outr(3));
    wr(4, HALT_W);
    outq.delete();
    start_pulse();
    wait_halt("t1", 100);
    chk("t1_n", outq.size(), 1);
    chk("t1_o0", got_out(0), 8);
    chk("t1_pc", 32'(pc), 4);
    chk("t1_state", 32'(state), 3);
    chk("t1_halted", 32'(halted), 1);

    // 2: MUL, SUB, SLL, ALUI XOR
    wr(0, ldi(1, 8'h0F));
    wr(1, ldi(2, 8'h11));
    wr(2, alur(3, 1, 7, 2));
    wr(3, outr(3));
    wr(4, ldi(4, 3));
    wr(5, ldi(5, 5));
    wr(6, alur(6, 4, 1, 5));
    wr(7, outr(6));
    wr(8, ldi(1, 8'h81));
    wr(9, ldi(2, 9));
    wr(10, alur(3, 1, 5, 2));
    wr(11, outr(3));
    wr(12, alui(7, 1, 4, 4'hF));
    wr(13, outr(7));
    wr(14, HALT_W);
    outq.delete();
    start_pulse();
    wait_halt("t2", 200);
    chk("t2_n", outq.size(), 4);
    chk("t2_mul", got_out(0), 8'hFF);
    chk("t2_sub", got_out(1), 8'hFE);
    chk("t2_sll", got_out(2), 8'h02);
    chk("t2_xori", got_out(3), 8'h8E);
    chk("t2_pc", 32'(pc), 14);

    // 3: countdown loop, with a start pulse mid-run
    wr(0, ldi(1, 3));
    wr(1, outr(1));
    wr(2, alui(1, 1, 1, 1));
    wr(3, beqz(1, 5));
    wr(4, jmp(1));
    wr(5, HALT_W);
    outq.delete();
    start_pulse();
    repeat (4) @(negedge clk);
    start_pulse();
    wait_halt("t3", 200);
    chk("t3_n", outq.size(), 3);
    chk("t3_o0", got_out(0), 3);
    chk("t3_o1", got_out(1), 2);
    chk("t3_o2", got_out(2), 1);
    chk("t3_pc", 32'(pc), 5);

    // 4: back-pressure stall, IN
    wr(0, ldi(1, 7));
    wr(1, outr(1));
    wr(2, inp(2));
    wr(3, outr(2));
    wr(4, HALT_W);
    in_data   = 8'h3C;
    out_ready = 1'b0;
    outq.delete();
    start_pulse();
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (10) @(negedge clk);
    chk("t4_pc", 32'(pc), 3);
    chk("t4_state", 32'(state), 2);
    chk("t4_valid", 32'(out_valid), 1);
    chk("t4_data", 32'(out_data), 7);
    chk("t4_none", outq.size(), 0);
    out_ready = 1'b1;
    wait_halt("t4", 100);
    chk("t4_n", outq.size(), 2);
    chk("t4_o0", got_out(0), 7);
    chk("t4_o1", got_out(1), 8'h3C);
    chk("t4_hpc", 32'(pc), 4);

    // 5: pc wrap and ignored prog_we while running
    do_reset();
    wr(0, beqz(3, 2));
    wr(1, HALT_W);
    wr(2, ldi(3, 1));
    wr(3, ldi(1, 0));
    for (int i = 4; i < 15; i++)
      wr(i, alui(1, 1, 0, 1));
    wr(15, outr(1));
    outq.delete();
    wrap_seen = 1'b0;
    start_pulse();
    repeat (3) @(negedge clk);
    wr(1, ldi(7, 8'h55));
    wait_halt("t5", 300);
    chk("t5_wrap", 32'(wrap_seen), 1);
    chk("t5_pc", 32'(pc), 1);
    chk("t5_n", outq.size(), 1);
    chk("t5_o0", got_out(0), 11);
    outq.delete();
    start_pulse();
    wait_halt("t5b", 100);
    chk("t5b_pc", 32'(pc), 1);
    chk("t5b_n", outq.size(), 0);

    // 6: reset while stalled with a pending output
    wr(0, outr(1));
    wr(1, ldi(1, 8'h5A));
    wr(2, outr(1));
    wr(3, outr(1));
    wr(4, ldi(0, 8'h77));
    wr(5, outr(0));
    wr(6, HALT_W);
    out_ready = 1'b0;
    outq.delete();
    start_pulse();
    begin
      int n = 0;
      while (!(state == 2'd2 && pc == 4'd2 && out_valid) && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_stall_data", 32'(out_data), 11);
    chk("t6_stall_pc", 32'(pc), 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_state", 32'(state), 0);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_pc", 32'(pc), 0);
    chk("t6_rst_data", 32'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    outq.delete();
    start_pulse();
    wait_halt("t6", 200);
    chk("t6_n", outq.size(), 4);
    chk("t6_r1_cleared", got_out(0), 0);
    chk("t6_o1", got_out(1), 8'h5A);
    chk("t6_o2", got_out(2), 8'h5A);
    chk("t6_r0", got_out(3), 0);
    chk("t6_pc", 32'(pc), 6);

    // 7: prog_we and start in the same cycle
    outq.delete();
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = jmp(5);
    start     = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
    wait_halt("t7", 100);
    chk("t7_n", outq.size(), 1);
    chk("t7_o0", got_out(0), 0);
    chk("t7_pc", 32'(pc), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
